// File: rtl/mdu_unit.sv
// mdu_unit - multiply/divide unit for the E stage of the P7 pipeline.
//
// Executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency (busy flag)
// and handles single-cycle MTHI/MTLO writes. The result is computed at
// launch and parked in temp_hi/temp_lo. It is committed to HI/LO only on
// the final busy cycle, so HI/LO never show a partial update.
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high reset
//   start   launch request for MULT/MULTU/DIV/DIVU
//   mdu_op  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   A, B    forwarded rs / rt operands
//   req     exception/interrupt request; blocks any new operation this edge
//   busy    operation in progress
//   HI, LO  architectural HI/LO registers
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   temp_hi;
  logic [31:0]   temp_lo;
  logic          commit_result;

  logic signed [63:0] mult_s;
  logic [63:0]        mult_u;
  logic               neg_a;
  logic               neg_b;
  logic [31:0]        div_num;
  logic [31:0]        div_den;
  logic [31:0]        quot;
  logic [31:0]        rem;
  logic [31:0]        div_hi;
  logic [31:0]        div_lo;
  logic               launch;
  logic [31:0]        launch_hi;
  logic [31:0]        launch_lo;
  logic [CW-1:0]      launch_count;
  logic               launch_commit;

  assign busy = (state == RUN);

  // Signed division runs through the same unsigned divider on operand
  // magnitudes; signs are reapplied afterwards. The quotient follows the XOR
  // of the operand signs (truncation toward zero), and the remainder follows
  // the dividend's sign. 0x80000000 / -1 naturally wraps to 0x80000000.
  // A zero divisor is swapped for 1 only to keep the divider defined; that
  // result is never committed.
  always_comb begin
    mult_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    mult_u = {32'd0, A} * {32'd0, B};

    neg_a   = (mdu_op == OP_DIV) && A[31];
    neg_b   = (mdu_op == OP_DIV) && B[31];
    div_num = neg_a ? (~A + 32'd1) : A;
    div_den = (B == 32'd0) ? 32'd1 : (neg_b ? (~B + 32'd1) : B);
    quot    = div_num / div_den;
    rem     = div_num % div_den;
    div_lo  = (neg_a ^ neg_b) ? (~quot + 32'd1) : quot;
    div_hi  = neg_a ? (~rem + 32'd1) : rem;

    launch        = (state == IDLE) && start && !req &&
                    (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
    launch_hi     = 32'd0;
    launch_lo     = 32'd0;
    launch_count  = DIV_LOAD;
    launch_commit = (B != 32'd0);

    case (mdu_op)
      OP_MULT: begin
        launch_hi     = mult_s[63:32];
        launch_lo     = mult_s[31:0];
        launch_count  = MULT_LOAD;
        launch_commit = 1'b1;
      end
      OP_MULTU: begin
        launch_hi     = mult_u[63:32];
        launch_lo     = mult_u[31:0];
        launch_count  = MULT_LOAD;
        launch_commit = 1'b1;
      end
      default: begin
        launch_hi = div_hi;
        launch_lo = div_lo;
      end
    endcase
  end

  // The counter is loaded with the full latency at launch. The edge that sees
  // it at 1 is the last busy cycle, and HI/LO are written there. While
  // running, start, MTHI/MTLO and req are ignored, because the in-flight op
  // belongs to an older committed instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      temp_hi       <= 32'd0;
      temp_lo       <= 32'd0;
      commit_result <= 1'b0;
      HI            <= 32'd0;
      LO            <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state         <= RUN;
            count         <= launch_count;
            temp_hi       <= launch_hi;
            temp_lo       <= launch_lo;
            commit_result <= launch_commit;
          end else if (!req && (mdu_op == OP_MTHI)) begin
            HI <= A;
          end else if (!req && (mdu_op == OP_MTLO)) begin
            LO <= A;
          end
        end
        default: begin
          if (count == COUNT_ONE) begin
            state <= IDLE;
            count <= '0;
            if (commit_result) begin
              HI <= temp_hi;
              LO <= temp_lo;
            end
          end else begin
            count <= count - COUNT_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit - self-checking bench for mdu_unit.
//
// Expected HI/LO pairs come from a behavioural model that uses 64-bit
// integer arithmetic. They are pushed to a scoreboard queue when an
// operation is launched, then popped and compared when busy falls.
module tb_mdu_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;

  logic [63:0] sb[$];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdu_op(mdu_op),
    .A     (A),
    .B     (B),
    .req   (req),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle. Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model for the value HI/LO must hold once the op completes.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] cur_hi,
                                        input logic [31:0] cur_lo);
    longint sa, sb_v, q, r;
    logic [63:0] res;
    res = {cur_hi, cur_lo};
    case (op)
      3'd1: begin
        sa   = longint'(signed'(a));
        sb_v = longint'(signed'(b));
        q    = sa * sb_v;
        res  = q;
      end
      3'd2: res = {32'd0, a} * {32'd0, b};
      3'd3: if (b != 32'd0) begin
        sa   = longint'(signed'(a));
        sb_v = longint'(signed'(b));
        q    = sa / sb_v;
        r    = sa % sb_v;
        res  = {r[31:0], q[31:0]};
      end
      3'd4: if (b != 32'd0) res = {a % b, a / b};
      default: res = {cur_hi, cur_lo};
    endcase
    return res;
  endfunction

  // Launch an op with a single start pulse and record its expected result.
  // On return the bench is in the first busy cycle.
  task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    sb.push_back(model(op, a, b, exp_hi, exp_lo));
    step();
    start  = 1'b0;
    mdu_op = 3'd0;
  endtask

  // Expect busy for exactly n cycles with HI/LO unchanged, then check the
  // committed result against the scoreboard. req is raised during busy
  // cycle req_at (0 = never).
  task automatic wait_done(input int n, input int req_at, input string name);
    logic [63:0] exp;
    for (int i = 1; i <= n; i++) begin
      checks++;
      if (busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
        errors++;
        $display("[TB] FAIL %s busy cycle %0d: busy=%b HI=%h LO=%h, want busy=1 HI=%h LO=%h",
                 name, i, busy, HI, LO, exp_hi, exp_lo);
      end
      req = (i == req_at);
      step();
    end
    req = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s busy_end: busy=%b, want 0", name, busy);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard empty: HI=%h LO=%h", name, HI, LO);
    end else begin
      exp = sb.pop_front();
      if ({HI, LO} !== exp) begin
        errors++;
        $display("[TB] FAIL %s result: HI=%h LO=%h, want HI=%h LO=%h",
                 name, HI, LO, exp[63:32], exp[31:0]);
      end
      exp_hi = exp[63:32];
      exp_lo = exp[31:0];
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b HI=%h LO=%h, want 0/0/0", busy, HI, LO);
    end
    issue_op(3'd4, 32'd100, 32'd7);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_div: busy=%b HI=%h LO=%h, want 0/0/0", busy, HI, LO);
    end
    for (int i = 0; i < DIV_CYCLES + 2; i++) step();
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_no_late_write: busy=%b HI=%h LO=%h, want 0/0/0", busy, HI, LO);
    end
  endtask

  task automatic test_mult();
    issue_op(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done(MULT_CYCLES, 0, "mult_neg");
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("[TB] FAIL mult_const: HI=%h LO=%h, want ffffffff fffffffa", HI, LO);
    end
    issue_op(3'd2, 32'hFFFF_FFFE, 32'd3);
    wait_done(MULT_CYCLES, 0, "multu");
    checks++;
    if (HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("[TB] FAIL multu_const: HI=%h LO=%h, want 00000002 fffffffa", HI, LO);
    end
  endtask

  task automatic test_div();
    issue_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(DIV_CYCLES, 0, "div_neg");
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("[TB] FAIL div_const: HI=%h LO=%h, want ffffffff fffffffd", HI, LO);
    end
    issue_op(3'd4, 32'd7, 32'd2);
    wait_done(DIV_CYCLES, 0, "divu");
    issue_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(DIV_CYCLES, 0, "div_overflow");
    issue_op(3'd3, 32'd45, 32'hFFFF_FFF9);
    wait_done(DIV_CYCLES, 0, "div_neg_divisor");
    for (int i = 0; i < 4; i++) begin
      issue_op(3'(1 + (i % 4)), $urandom, $urandom_range(1, 32'hFFFF));
      wait_done((i % 4) < 2 ? MULT_CYCLES : DIV_CYCLES, 0, "random_op");
    end
  endtask

  task automatic test_mthi_mtlo();
    mdu_op = 3'd5;
    A = 32'h1234_5678;
    step();
    mdu_op = 3'd0;
    exp_hi = 32'h1234_5678;
    checks++;
    if (HI !== 32'h1234_5678 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mthi: HI=%h busy=%b, want 12345678 0", HI, busy);
    end
    mdu_op = 3'd6;
    A = 32'hDEAD_BEEF;
    req = 1'b1;
    step();
    req = 1'b0;
    mdu_op = 3'd0;
    checks++;
    if (LO !== exp_lo) begin
      errors++;
      $display("[TB] FAIL mtlo_req: LO=%h, want %h", LO, exp_lo);
    end
    mdu_op = 3'd5;
    A = 32'h11;
    step();
    mdu_op = 3'd6;
    A = 32'h22;
    step();
    mdu_op = 3'd0;
    exp_hi = 32'h11;
    exp_lo = 32'h22;
    checks++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      errors++;
      $display("[TB] FAIL mt_setup: HI=%h LO=%h, want 11 22", HI, LO);
    end
    issue_op(3'd3, 32'd99, 32'd0);
    wait_done(DIV_CYCLES, 0, "div_by_zero");
  endtask

  task automatic test_req();
    start = 1'b1;
    mdu_op = 3'd1;
    A = 32'd9;
    B = 32'd9;
    req = 1'b1;
    step();
    start = 1'b0;
    mdu_op = 3'd0;
    req = 1'b0;
    checks++;
    if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      errors++;
      $display("[TB] FAIL req_blocks_start: busy=%b HI=%h LO=%h, want 0 %h %h",
               busy, HI, LO, exp_hi, exp_lo);
    end
    issue_op(3'd3, 32'd100, 32'd7);
    wait_done(DIV_CYCLES, 2, "div_req_in_run");
  endtask

  task automatic test_back_to_back();
    issue_op(3'd2, 32'd3, 32'd4);
    // Hold a second start across the whole busy window and the completion edge.
    start = 1'b1;
    mdu_op = 3'd4;
    A = 32'd50;
    B = 32'd6;
    wait_done(MULT_CYCLES, 0, "b2b_first");
    sb.push_back(model(3'd4, 32'd50, 32'd6, exp_hi, exp_lo));
    step();
    start = 1'b0;
    mdu_op = 3'd0;
    wait_done(DIV_CYCLES, 0, "b2b_second");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = 3'd0;
    A      = 32'd0;
    B      = 32'd0;
    req    = 1'b0;
    step();
    step();
    reset = 1'b0;
    $display("[TB] starting mdu_unit tests");
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_req();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
